// File: rtl/shift_unit_arbiter_if.sv
// Handshake and datapath bundle between requesters, the arbiter and the shared shift unit.
// slave is the arbiter's view; master is the view of the surrounding requesters/shifter/consumer.
interface shift_unit_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_rs1_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_rs2_i;
  logic [NUM_REQ-1:0][5:0]            req_imm_i;
  logic [NUM_REQ-1:0][3:0]            req_func_i;

  logic [DATA_WIDTH-1:0] sh_rs1_o;
  logic [DATA_WIDTH-1:0] sh_rs2_o;
  logic [5:0]            sh_imm_o;
  logic [3:0]            sh_func_o;
  logic [DATA_WIDTH-1:0] sh_result_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic [ID_W-1:0]       rsp_id_o;
  logic                  rsp_err_o;

  modport slave (
    input  req_valid_i, req_rs1_i, req_rs2_i, req_imm_i, req_func_i, sh_result_i, rsp_ready_i,
    output req_ready_o, sh_rs1_o, sh_rs2_o, sh_imm_o, sh_func_o,
    output rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_rs1_i, req_rs2_i, req_imm_i, req_func_i, sh_result_i, rsp_ready_i,
    input  req_ready_o, sh_rs1_o, sh_rs2_o, sh_imm_o, sh_func_o,
    input  rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one combinational shift unit among NUM_REQ requesters.
// One op in flight: IDLE (grant) -> EXEC (shifter driven) -> RESP (held until consumed).
module shift_unit_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  shift_unit_arbiter_if.slave  bus
);

  localparam logic [3:0] FUNC_SLL  = 4'h0;
  localparam logic [3:0] FUNC_SLLI = 4'h1;
  localparam logic [3:0] FUNC_SLR  = 4'h2;
  localparam logic [3:0] FUNC_SLRI = 4'h3;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_op_id;
  logic [DATA_WIDTH-1:0] r_op_rs1;
  logic [DATA_WIDTH-1:0] r_op_rs2;
  logic [5:0]            r_op_imm;
  logic [3:0]            r_op_func;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  logic                  w_found;
  logic [ID_W-1:0]       w_grant;
  logic [ID_W:0]         w_cand;
  logic [3:0]            w_func;
  logic                  w_legal;
  logic                  w_accept;

  // Search upward from rr_ptr+1 (mod NUM_REQ); the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && bus.req_valid_i[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_func  = bus.req_func_i[w_grant];
  assign w_legal = (w_func == FUNC_SLL) || (w_func == FUNC_SLLI) ||
                   (w_func == FUNC_SLR) || (w_func == FUNC_SLRI);

  always_comb begin
    w_state_d       = r_state;
    w_accept        = 1'b0;
    bus.req_ready_o = '0;
    case (r_state)
      StIdle: begin
        // Ready is masked while reset is held so the grant cannot be seen early.
        if (w_found && arst_ni) begin
          bus.req_ready_o[w_grant] = 1'b1;
          w_accept                 = 1'b1;
          w_state_d                = w_legal ? StExec : StResp;
        end
      end
      StExec: w_state_d = StResp;
      StResp: begin
        if (bus.rsp_ready_i) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= StIdle;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_op_id    <= '0;
      r_op_rs1   <= '0;
      r_op_rs2   <= '0;
      r_op_imm   <= '0;
      r_op_func  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op_rs1  <= bus.req_rs1_i[w_grant];
        r_op_rs2  <= bus.req_rs2_i[w_grant];
        r_op_imm  <= bus.req_imm_i[w_grant];
        r_op_func <= w_func;
        r_op_id   <= w_grant;
        r_rr_ptr  <= w_grant;
        if (!w_legal) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == StExec) begin
        r_rsp_data <= bus.sh_result_i;
        r_rsp_err  <= 1'b0;
      end
    end
  end

  assign bus.sh_rs1_o    = r_op_rs1;
  assign bus.sh_rs2_o    = r_op_rs2;
  assign bus.sh_imm_o    = r_op_imm;
  assign bus.sh_func_o   = r_op_func;
  assign bus.rsp_valid_o = (r_state == StResp);
  assign bus.rsp_data_o  = r_rsp_data;
  assign bus.rsp_id_o    = r_op_id;
  assign bus.rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of grant order, latency and shift results.
module tb_shift_unit_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;

  localparam logic [3:0] F_SLL  = 4'h0;
  localparam logic [3:0] F_SLLI = 4'h1;
  localparam logic [3:0] F_SLR  = 4'h2;
  localparam logic [3:0] F_SLRI = 4'h3;
  localparam logic [3:0] F_BAD  = 4'hF;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  shift_unit_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  shift_unit_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  // Shift unit: illegal funcs yield a marker so any accidental sampling is visible.
  function automatic logic [31:0] ref_shift(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [5:0] imm);
    case (f)
      F_SLL:   return a << b[4:0];
      F_SLLI:  return a << imm[4:0];
      F_SLR:   return a >> b[4:0];
      F_SLRI:  return a >> imm[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.sh_result_i = ref_shift(bus.sh_func_o, bus.sh_rs1_o, bus.sh_rs2_o, bus.sh_imm_o);

  task automatic clear_reqs();
    bus.req_valid_i = '0;
    bus.req_rs1_i   = '0;
    bus.req_rs2_i   = '0;
    bus.req_imm_i   = '0;
    bus.req_func_i  = '0;
  endtask

  task automatic set_req(input logic [IW-1:0] r, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] imm);
    bus.req_valid_i[r] = 1'b1;
    bus.req_func_i[r]  = f;
    bus.req_rs1_i[r]   = a;
    bus.req_rs2_i[r]   = b;
    bus.req_imm_i[r]   = imm;
  endtask

  task automatic test_reset();
    arst_n          = 1'b0;
    bus.rsp_ready_i = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0h, expected 0", bus.rsp_valid_o);
    end
    n_checks++;
    if ({bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o} !== 34'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %0h/%0h/%0h, expected 0/0/0",
                         bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o);
    end
    n_checks++;
    if ({bus.sh_rs1_o, bus.sh_rs2_o, bus.sh_imm_o, bus.sh_func_o} !== 74'h0) begin
      n_fail++; $display("FAIL reset_sh: got %0h/%0h, expected 0/0", bus.sh_rs1_o, bus.sh_func_o);
    end
    // Requests presented while reset is still low.
    set_req(1'b0, F_SLLI, 32'h1, 32'h0, 6'd3);
    set_req(1'b1, F_SLL, 32'h5, 32'h1, 6'd0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b, expected 00", bus.req_ready_o);
    end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant: got %b, expected 01", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_exec_valid: got %0h, expected 0", bus.rsp_valid_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o} !== {1'b1, 32'h8, 1'b0}) begin
      n_fail++; $display("FAIL reset_first_rsp: got v=%0h d=%0h id=%0h, expected v=1 d=8 id=0",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_sll();
    set_req(1'b0, F_SLL, 32'h0000_00F0, 32'd4, 6'd0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b01) begin
      n_fail++; $display("FAIL sll_ready: got %b, expected 01", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    n_checks++;
    if ({bus.rsp_valid_o, bus.sh_rs1_o, bus.sh_rs2_o, bus.sh_func_o} !==
        {1'b0, 32'h0000_00F0, 32'd4, F_SLL}) begin
      n_fail++; $display("FAIL sll_exec: got v=%0h rs1=%0h rs2=%0h f=%0h, expected v=0 rs1=f0 rs2=4 f=0",
                         bus.rsp_valid_o, bus.sh_rs1_o, bus.sh_rs2_o, bus.sh_func_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o} !==
        {1'b1, 32'h0000_0F00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sll_rsp: got v=%0h d=%0h id=%0h e=%0h, expected v=1 d=f00 id=0 e=0",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL sll_done: got %0h, expected 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_illegal();
    set_req(1'b1, F_BAD, 32'h1234_5678, 32'd3, 6'd2);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b10) begin
      n_fail++; $display("FAIL illegal_ready: got %b, expected 10", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o} !==
        {1'b1, 32'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL illegal_rsp: got v=%0h d=%0h id=%0h e=%0h, expected v=1 d=0 id=1 e=1",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL illegal_done: got %0h, expected 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int exp_g[4] = '{0, 1, 0, 1};
    int grants = 0;
    int resps  = 0;
    logic [31:0] exp_d;
    bus.rsp_ready_i = 1'b1;
    set_req(1'b0, F_SLRI, 32'h8000_0001, 32'd0, 6'd1);
    set_req(1'b1, F_SLL, 32'h8000_0001, 32'd8, 6'd0);
    for (int cyc = 0; cyc < 40 && resps < 4; cyc++) begin
      #1;
      if (bus.req_ready_o !== 2'b00 && grants < 4) begin
        n_checks++;
        if (bus.req_ready_o !== (NR'(1) << exp_g[grants])) begin
          n_fail++; $display("FAIL b2b_grant%0d: got %b, expected requester %0d",
                             grants, bus.req_ready_o, exp_g[grants]);
        end
        grants++;
      end
      if (bus.rsp_valid_o === 1'b1 && resps < 4) begin
        exp_d = (exp_g[resps] == 0) ? 32'h4000_0000 : 32'h0000_0100;
        n_checks++;
        if ({bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o} !== {exp_d, IW'(exp_g[resps]), 1'b0}) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got d=%0h id=%0h e=%0h, expected d=%0h id=%0d e=0",
                             resps, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o, exp_d, exp_g[resps]);
        end
        resps++;
      end
      @(posedge clk); #1;
      if (grants == 4) clear_reqs();
    end
    n_checks++;
    if (resps != 4 || grants != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d grants %0d responses, expected 4 and 4", grants, resps);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready_i = 1'b0;
    set_req(1'b0, F_SLR, 32'hF000_0000, 32'd4, 6'd0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b01) begin
      n_fail++; $display("FAIL bp_ready: got %b, expected 01", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    set_req(1'b1, F_SLL, 32'h7, 32'd1, 6'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.req_ready_o} !==
          {1'b1, 32'h0F00_0000, 1'b0, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%0h d=%0h id=%0h rdy=%b, expected v=1 d=f000000 id=0 rdy=00",
                           i, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.req_ready_o);
      end
      @(posedge clk); #1;
    end
    clear_reqs();
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got %0h, expected 0", bus.rsp_valid_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_single: got %0h, expected 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_reset_in_exec();
    set_req(1'b1, F_SLL, 32'h3, 32'd2, 6'd0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b10) begin
      n_fail++; $display("FAIL rst_exec_ready: got %b, expected 10", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    #2;
    arst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o, bus.sh_rs1_o, bus.req_ready_o} !== '0) begin
      n_fail++; $display("FAIL rst_exec_outputs: got v=%0h d=%0h id=%0h e=%0h rs1=%0h, expected all 0",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o, bus.sh_rs1_o);
    end
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_exec_no_rsp%0d: got %0h, expected 0", i, bus.rsp_valid_o);
      end
    end
    set_req(1'b0, F_SLL, 32'h1, 32'd1, 6'd0);
    set_req(1'b1, F_SLR, 32'h8, 32'd1, 6'd0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 2'b01) begin
      n_fail++; $display("FAIL rst_exec_regrant: got %b, expected 01", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o} !== {1'b1, 32'h2, 1'b0}) begin
      n_fail++; $display("FAIL rst_exec_rsp: got v=%0h d=%0h id=%0h, expected v=1 d=2 id=0",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o);
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic          err;
  } rsp_t;

  task automatic test_random();
    rsp_t          q[$];
    rsp_t          exp_rsp;
    int            m_ptr;
    int            m_phase;  // 0 waiting for grant, 1 shifting, 2 response pending
    int            g;
    int            c;
    logic [NR-1:0] exp_ready;
    logic          legal;
    logic [3:0]    f[NR];
    logic [31:0]   a[NR];
    logic [31:0]   b[NR];
    logic [5:0]    imm[NR];
    logic [NR-1:0] v;
    arst_n = 1'b0;
    clear_reqs();
    @(posedge clk); #1;
    arst_n  = 1'b1;
    m_ptr   = NR - 1;
    m_phase = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        v[r]   = ($urandom_range(0, 9) < 6);
        f[r]   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
        a[r]   = $urandom;
        b[r]   = $urandom;
        imm[r] = 6'($urandom_range(0, 63));
      end
      bus.req_valid_i = v;
      for (int r = 0; r < NR; r++) begin
        bus.req_func_i[r] = f[r];
        bus.req_rs1_i[r]  = a[r];
        bus.req_rs2_i[r]  = b[r];
        bus.req_imm_i[r]  = imm[r];
      end
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      #2;
      g = -1;
      exp_ready = '0;
      if (m_phase == 0) begin
        for (int k = 1; k <= NR; k++) begin
          c = (m_ptr + k) % NR;
          if (g < 0 && v[c]) g = c;
        end
        if (g >= 0) exp_ready = NR'(1) << g;
      end
      n_checks++;
      if (bus.req_ready_o !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready cyc%0d: got %b, expected %b", cyc, bus.req_ready_o, exp_ready);
      end
      n_checks++;
      if (bus.rsp_valid_o !== (m_phase == 2)) begin
        n_fail++; $display("FAIL rnd_valid cyc%0d: got %0h, expected %0d", cyc, bus.rsp_valid_o, m_phase == 2);
      end
      if (m_phase == 2 && q.size() > 0) begin
        exp_rsp = q[0];
        n_checks++;
        if ({bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o} !== exp_rsp) begin
          n_fail++; $display("FAIL rnd_rsp cyc%0d: got d=%0h id=%0h e=%0h, expected d=%0h id=%0h e=%0h",
                             cyc, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o,
                             exp_rsp.data, exp_rsp.id, exp_rsp.err);
        end
      end
      case (m_phase)
        0: begin
          if (g >= 0) begin
            legal = (f[g] < 4'd4);
            q.push_back('{data: legal ? ref_shift(f[g], a[g], b[g], imm[g]) : 32'h0,
                          id: IW'(g), err: !legal});
            m_ptr   = g;
            m_phase = legal ? 1 : 2;
          end
        end
        1: m_phase = 2;
        default: begin
          if (bus.rsp_ready_i) begin
            void'(q.pop_front());
            m_phase = 0;
          end
        end
      endcase
      @(posedge clk); #1;
    end
    clear_reqs();
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: got %0h, expected 0", bus.rsp_valid_o);
    end
  endtask

  initial begin
    bus.rsp_ready_i = 1'b1;
    clear_reqs();
    test_reset();
    test_single_sll();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_in_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end
endmodule
